// File: rtl/uart_rx_ctrl_pkg.sv
// uart_rx_ctrl_pkg: shared UART state encoding, default timing constants and a width helper
package uart_rx_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
   localparam int DATA_BITS_DEF = 8;
   localparam int OVERSAMPLE_DEF = 16;
   localparam int CLKS_PER_TICK_DEF = 54;
   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: receive-side line and shift-register handshake bundle
//   rx_in, rx_en             : serial line and start-detect enable (driven by master)
//   serial_bit, shift_en     : voted bit and its one-cycle strobe (driven by slave)
//   busy, frame_done, frame_err : frame status (driven by slave)
interface uart_rx_ctrl_if;
   logic rx_in;
   logic rx_en;
   logic serial_bit;
   logic shift_en;
   logic busy;
   logic frame_done;
   logic frame_err;
   modport master (output rx_in, rx_en, input serial_bit, shift_en, busy, frame_done, frame_err);
   modport slave (input rx_in, rx_en, output serial_bit, shift_en, busy, frame_done, frame_err);
endinterface

// File: rtl/uart_rx_ctrl_tick_gen.sv
// uart_tick_gen: clearable divider producing a one-clk tick every DIV clks
//   clk, rst : clock and asynchronous active-high reset
//   clr_i    : holds the divider at zero and suppresses the tick
//   tick_o   : one-cycle pulse, first one DIV clks after clr_i drops
module uart_tick_gen
   import uart_rx_ctrl_pkg::*;
#(
   parameter int DIV = CLKS_PER_TICK_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic tick_o
);
   localparam int W = clog2(DIV);
   localparam logic [W-1:0] LAST = W'(DIV - 1);
   logic [W-1:0] cnt_q;
   assign tick_o = !clr_i && cnt_q == LAST;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else cnt_q <= (clr_i || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive front end - sync, oversample, start validation, 2-of-3 bit vote
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of uart_rx_ctrl_if (rx_in/rx_en in; serial_bit, shift_en,
//              busy, frame_done, frame_err out)
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int CLKS_PER_TICK = CLKS_PER_TICK_DEF
) (
   input logic clk,
   input logic rst,
   uart_rx_ctrl_if.slave bus
);
   localparam int MID = OVERSAMPLE / 2;
   localparam int SW = clog2(OVERSAMPLE);
   localparam int BW = clog2(DATA_BITS);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_LO = SW'(MID - 1);
   localparam logic [SW-1:0] S_MID = SW'(MID);
   localparam logic [SW-1:0] S_HI = SW'(MID + 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
   uart_state_e state_q;
   logic [1:0] sync_q;
   logic [SW-1:0] scnt_q, scnt_d;
   logic [BW-1:0] bcnt_q;
   logic [1:0] smp_q;
   logic serial_bit_q, shift_en_q, busy_q, frame_done_q, frame_err_q;
   logic rx_s, tick, wrap, decide, vote;
   assign rx_s = sync_q[1];
   uart_tick_gen #(.DIV(CLKS_PER_TICK)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clr_i (state_q == IDLE),
      .tick_o(tick)
   );
   // The count is the tick index within the bit; samples are taken as the count arrives.
   always_comb begin
      scnt_d = (scnt_q == S_LAST) ? '0 : scnt_q + 1'b1;
      wrap = tick && scnt_d == '0;
      decide = tick && scnt_d == S_HI;
      vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         sync_q <= 2'b11;
         scnt_q <= '0;
         bcnt_q <= '0;
         smp_q <= '0;
         serial_bit_q <= 1'b0;
         shift_en_q <= 1'b0;
         busy_q <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], bus.rx_in};
         shift_en_q <= 1'b0;
         frame_done_q <= 1'b0;
         if (tick) begin
            scnt_q <= scnt_d;
            if (scnt_d == S_LO) smp_q[0] <= rx_s;
            if (scnt_d == S_MID) smp_q[1] <= rx_s;
         end
         case (state_q)
            IDLE:
               if (bus.rx_en && !rx_s) begin
                  state_q <= START;
                  busy_q <= 1'b1;
                  scnt_q <= '0;
                  bcnt_q <= '0;
               end
            START:
               if (decide && vote) begin
                  state_q <= IDLE;
                  busy_q <= 1'b0;
               end else if (wrap) state_q <= DATA;
            DATA: begin
               if (decide) begin
                  serial_bit_q <= vote;
                  shift_en_q <= 1'b1;
               end
               if (wrap) begin
                  if (bcnt_q == B_LAST) state_q <= STOP;
                  else bcnt_q <= bcnt_q + 1'b1;
               end
            end
            STOP:
               // Leaving at mid-stop lets a back-to-back start edge be caught.
               if (decide) begin
                  frame_done_q <= 1'b1;
                  frame_err_q <= ~vote;
                  state_q <= IDLE;
                  busy_q <= 1'b0;
               end
            default: state_q <= IDLE;
         endcase
      end
   assign bus.serial_bit = serial_bit_q;
   assign bus.shift_en = shift_en_q;
   assign bus.busy = busy_q;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed + randomized frames checked against a frame-level receive model
module tb_uart_rx_ctrl;
   localparam int DB = 8;
   localparam int OS = 16;
   localparam int CPT = 4;
   localparam int BIT = OS * CPT;
   // line edge -> 2 sync flops + detect, then (OS+MID+1) ticks, then registered strobe
   localparam int LAT = 3 + (OS + OS / 2 + 1) * CPT;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int cyc = 0;
   int tests = 0;
   int fails = 0;
   int overlap = 0;
   int last_start = 0;
   logic got_bits[$];
   int got_t[$];
   logic got_err[$];
   logic exp_bits[$];
   int exp_start[$];
   logic exp_err[$];
   uart_rx_ctrl_if bus ();
   uart_rx_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS), .CLKS_PER_TICK(CPT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (!rst) begin
         if (bus.shift_en) begin
            got_bits.push_back(bus.serial_bit);
            got_t.push_back(cyc);
         end
         if (bus.frame_done) begin
            got_err.push_back(bus.frame_err);
            tests++;
            assert (bus.busy === 1'b0) else begin
               fails++;
               $error("FAIL busy_at_done got=%0b exp=0", bus.busy);
            end
         end
         if (bus.shift_en && bus.frame_done) overlap++;
      end
   task automatic expect_frame(input logic [7:0] d, input int n, input logic done, input logic err);
      for (int k = 0; k < n; k++) exp_bits.push_back(d[k]);
      exp_start.push_back(last_start);
      if (done) exp_err.push_back(err);
   endtask
   task automatic check(input string tag);
      tests++;
      assert (got_bits.size() === exp_bits.size()) else begin
         fails++;
         $error("FAIL %s pulses got=%0d exp=%0d", tag, got_bits.size(), exp_bits.size());
      end
      for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++) begin
         tests++;
         assert (got_bits[i] === exp_bits[i]) else begin
            fails++;
            $error("FAIL %s bit%0d got=%0b exp=%0b", tag, i, got_bits[i], exp_bits[i]);
         end
      end
      for (int i = 0; i < got_t.size(); i++) begin
         if (i % DB == 0) begin
            if (i / DB < exp_start.size()) begin
               tests++;
               assert (got_t[i] - exp_start[i / DB] === LAT) else begin
                  fails++;
                  $error("FAIL %s latency%0d got=%0d exp=%0d", tag, i, got_t[i] - exp_start[i / DB], LAT);
               end
            end
         end else begin
            tests++;
            assert (got_t[i] - got_t[i - 1] === BIT) else begin
               fails++;
               $error("FAIL %s spacing%0d got=%0d exp=%0d", tag, i, got_t[i] - got_t[i - 1], BIT);
            end
         end
      end
      tests++;
      assert (got_err.size() === exp_err.size()) else begin
         fails++;
         $error("FAIL %s frame_done got=%0d exp=%0d", tag, got_err.size(), exp_err.size());
      end
      for (int i = 0; i < got_err.size() && i < exp_err.size(); i++) begin
         tests++;
         assert (got_err[i] === exp_err[i]) else begin
            fails++;
            $error("FAIL %s frame_err%0d got=%0b exp=%0b", tag, i, got_err[i], exp_err[i]);
         end
      end
      tests++;
      assert (overlap === 0) else begin
         fails++;
         $error("FAIL %s overlap got=%0d exp=0", tag, overlap);
      end
      got_bits.delete();
      got_t.delete();
      got_err.delete();
      exp_bits.delete();
      exp_start.delete();
      exp_err.delete();
   endtask
   task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit,
                             input int rst_bit, input int drop_bit, input int gap);
      logic [9:0] line;
      line = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++)
         for (int t = 0; t < BIT; t++) begin
            @(negedge clk);
            if (i == 0 && t == 0) last_start = cyc;
            bus.rx_in = (glitch_bit >= 0 && i == glitch_bit + 1 && t >= 30 && t < 34) ? ~line[i] : line[i];
            if (drop_bit >= 0 && i == drop_bit + 1 && t == 0) bus.rx_en = 1'b0;
            if (rst_bit >= 0 && i == rst_bit + 1 && t == 20) begin
               rst = 1'b1;
               #1;
               tests++;
               assert ({bus.serial_bit, bus.shift_en, bus.busy, bus.frame_done, bus.frame_err} === 5'b0) else begin
                  fails++;
                  $error("FAIL rst_mid_frame got=%b exp=00000",
                         {bus.serial_bit, bus.shift_en, bus.busy, bus.frame_done, bus.frame_err});
               end
            end
            if (rst_bit >= 0 && i == rst_bit + 1 && t == 22) rst = 1'b0;
         end
      bus.rx_in = 1'b1;
      repeat (gap) @(negedge clk);
   endtask
   initial begin
      logic [7:0] d;
      logic stop;
      bus.rx_in = 1'b1;
      bus.rx_en = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      assert ({bus.serial_bit, bus.shift_en, bus.busy, bus.frame_done, bus.frame_err} === 5'b0) else begin
         fails++;
         $error("FAIL reset_state got=%b exp=00000",
                {bus.serial_bit, bus.shift_en, bus.busy, bus.frame_done, bus.frame_err});
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      tests++;
      assert (bus.busy === 1'b0) else begin
         fails++;
         $error("FAIL idle_busy got=%0b exp=0", bus.busy);
      end
      send_frame(8'hA5, 1'b1, -1, -1, -1, 100);
      expect_frame(8'hA5, DB, 1'b1, 1'b0);
      check("a5");
      bus.rx_in = 1'b0;
      repeat (10) @(negedge clk);
      tests++;
      assert (bus.busy === 1'b1) else begin
         fails++;
         $error("FAIL false_start_busy got=%0b exp=1", bus.busy);
      end
      repeat (10) @(negedge clk);
      bus.rx_in = 1'b1;
      repeat (200) @(negedge clk);
      tests++;
      assert (bus.busy === 1'b0) else begin
         fails++;
         $error("FAIL false_start_idle got=%0b exp=0", bus.busy);
      end
      check("false_start");
      send_frame(8'h3C, 1'b0, -1, -1, -1, 100);
      expect_frame(8'h3C, DB, 1'b1, 1'b1);
      check("3c_bad_stop");
      tests++;
      assert (bus.frame_err === 1'b1) else begin
         fails++;
         $error("FAIL frame_err_hold got=%0b exp=1", bus.frame_err);
      end
      send_frame(8'hFF, 1'b1, -1, -1, -1, 100);
      expect_frame(8'hFF, DB, 1'b1, 1'b0);
      check("ff");
      tests++;
      assert (bus.frame_err === 1'b0) else begin
         fails++;
         $error("FAIL frame_err_clear got=%0b exp=0", bus.frame_err);
      end
      send_frame(8'h00, 1'b1, 3, -1, -1, 100);
      expect_frame(8'h00, DB, 1'b1, 1'b0);
      check("glitch");
      d = {4'hF, 4'($urandom)};
      send_frame(d, 1'b1, -1, 4, -1, 100);
      expect_frame(d, 4, 1'b0, 1'b0);
      check("rst_mid");
      send_frame(8'h5A, 1'b1, -1, -1, -1, 100);
      expect_frame(8'h5A, DB, 1'b1, 1'b0);
      check("5a_after_rst");
      send_frame(8'h01, 1'b1, -1, -1, 2, 0);
      expect_frame(8'h01, DB, 1'b1, 1'b0);
      send_frame(8'h80, 1'b1, -1, -1, -1, 100);
      check("b2b_rx_en_low");
      bus.rx_en = 1'b1;
      send_frame(8'h01, 1'b1, -1, -1, -1, 0);
      expect_frame(8'h01, DB, 1'b1, 1'b0);
      send_frame(8'h80, 1'b1, -1, -1, -1, 100);
      expect_frame(8'h80, DB, 1'b1, 1'b0);
      check("b2b");
      for (int n = 0; n < 8; n++) begin
         d = 8'($urandom);
         stop = ($urandom_range(3) != 0);
         send_frame(d, stop, -1, -1, -1, 80 + int'($urandom_range(60)));
         expect_frame(d, DB, 1'b1, ~stop);
         check("rand");
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side front end of the UART. Sits directly upstream of the 8-bit shift register on the receive path.
- Synchronises and oversamples the asynchronous rx line, detects and validates the start bit, and majority-votes each bit at mid-period.
- Drives the shift register's serial input and shift-enable, one pulse per data bit.
- Flags frame completion and stop-bit (framing) errors to the host logic.

Parameters:
DATA_BITS, 8, data bits per frame; must equal the downstream shift register depth
OVERSAMPLE, 16, ticks per bit period; even, at least 8
CLKS_PER_TICK, 54, clk cycles per oversample tick (100 MHz, 115200 baud, x16)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
rx_in  input  1  raw asynchronous serial line; idle high
rx_en  input  1  enables start-bit detection
serial_bit  output  1  voted data bit, to the shift register serial input
shift_en  output  1  one-cycle pulse; shift register samples serial_bit
busy  output  1  high while a frame is in progress (any state except IDLE)
frame_done  output  1  one-cycle pulse at the stop-bit decision
frame_err  output  1  stop bit sampled low; valid from frame_done until the next frame_done

Behaviour:
- Reset (async, active-high):
  - state=IDLE; both synchroniser flops=1.
  - serial_bit=0, shift_en=0, busy=0, frame_done=0, frame_err=0.
  - tick, sample and bit counters=0.
- Sync: 2-flop synchroniser on rx_in; all decisions use the synchronised signal rx_s.
- Tick generator:
  - tick is a one-clk pulse every CLKS_PER_TICK clks.
  - It is held at 0 in IDLE and restarts at 0 on the start-detect cycle, so the first tick comes CLKS_PER_TICK clks after detection.
- Sample counter: 0..OVERSAMPLE-1, advances on tick, wraps at OVERSAMPLE-1. MID=OVERSAMPLE/2.
- Vote: samples at counts MID-1, MID, MID+1; the bit is the 2-of-3 majority, decided on the tick at count MID+1.
- FSM states:
  - IDLE: if rx_en=1 and rx_s=0, go to START and clear the counters. rx_en=0 ignores the line.
  - START: at the MID+1 decision, vote=1 means false start -> IDLE (no outputs). Vote=0 means stay until the count wraps to 0, then go to DATA with bit counter=0.
  - DATA: at each MID+1 decision, register serial_bit=vote and pulse shift_en for exactly one clk, in the cycle after the deciding tick. The bit counter increments on the count wrap; after DATA_BITS bits go to STOP at the wrap.
  - STOP: at the MID+1 decision, pulse frame_done for one clk (same cycle timing as shift_en), set frame_err=~vote, and go to IDLE in that same cycle. Returning mid-stop lets a back-to-back start bit be detected.
- serial_bit holds its last value between pulses. shift_en and frame_done are never high in the same cycle.
- Exactly DATA_BITS shift_en pulses per valid start, including frames that end in a framing error.
- Bit order on serial_bit is line order (LSB first). Reordering is the consumer's responsibility.
- rx_en deasserted mid-frame: the current frame completes normally; only new start detection is gated.
- Reset mid-frame: immediate return to IDLE with all outputs cleared, and no frame_done.
- Sampling point: nominal start-detect-to-data-bit-0 decision = (OVERSAMPLE+MID+1)·CLKS_PER_TICK clks, plus synchroniser latency.

Decomposition:
- Shared uart package:
  - FSM state encoding (IDLE, START, DATA, STOP).
  - Default OVERSAMPLE/CLKS_PER_TICK constants.
  - A clog2 helper for counter widths.
- One natural sub-module: uart_tick_gen (clear-able tick divider), reused later by the TX controller.

Test Plan:
- CLKS_PER_TICK=4, OVERSAMPLE=16 (64 clks/bit); send 0xA5 (line bits 1,0,1,0,0,1,0,1, stop=1) -> 8 shift_en pulses 64 clks apart, serial_bit at the pulses = 1,0,1,0,0,1,0,1; one frame_done with frame_err=0; busy falls at frame_done.
- rx_in low for 20 clks then high -> START aborts at the MID+1 decision; no shift_en, no frame_done; back in IDLE (busy=0).
- Send 0x3C with stop bit=0 -> 8 shift_en pulses, frame_done with frame_err=1. Next good frame 0xFF -> frame_err returns to 0.
- 0x00 frame with rx_in forced high for exactly one tick window at count MID of bit 3 -> serial_bit for bit 3 is still 0 (majority).
- Assert rst for 2 clks during bit 4 -> outputs are 0 within the reset cycle, no further shift_en; the following frame 0x5A is received correctly.
- Two back-to-back frames 0x01, 0x80 with no idle gap, and rx_en dropped during the first -> first frame completes, second start ignored, no pulses. Repeat with rx_en=1 -> 16 shift_en pulses and 2 frame_done pulses.
